// File: rtl/decode_stage.sv
// Instruction-decode stage of the 5-stage MIPS pipeline: decode, GPR read,
// EX/MEM operand forwarding, load-use stall detection and the ID/EX register.
module decode_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_inst,
    output logic        gpr_re1,
    output logic        gpr_re2,
    output logic [4:0]  gpr_raddr1,
    output logic [4:0]  gpr_raddr2,
    input  logic [31:0] gpr_rdata1,
    input  logic [31:0] gpr_rdata2,
    input  logic        ex_we,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        mem_we,
    input  logic [4:0]  mem_waddr,
    input  logic [31:0] mem_wdata,
    output logic        stall_req,
    output logic        idex_valid,
    output logic [2:0]  idex_alu_op,
    output logic [31:0] idex_opnd1,
    output logic [31:0] idex_opnd2,
    output logic [31:0] idex_store_data,
    output logic        idex_mem_read,
    output logic        idex_mem_write,
    output logic        idex_wreg_en,
    output logic [4:0]  idex_wreg_addr,
    output logic [31:0] idex_pc,
    output logic        idex_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_AND   = 3'd2;
    localparam logic [2:0] ALU_OR    = 3'd3;
    localparam logic [2:0] ALU_XOR   = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;
    localparam logic [2:0] ALU_PASS2 = 3'd6;

    typedef struct packed {
        logic        valid;
        logic [2:0]  alu_op;
        logic [31:0] opnd1;
        logic [31:0] opnd2;
        logic [31:0] store_data;
        logic        mem_read;
        logic        mem_write;
        logic        wreg_en;
        logic [4:0]  wreg_addr;
        logic [31:0] pc;
        logic        illegal;
    } idex_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic        has_dest;
    logic        load_hit1;
    logic        load_hit2;
    idex_t       dec;
    idex_t       bubble;
    idex_t       idex;

    assign opcode   = if_inst[31:26];
    assign rs       = if_inst[25:21];
    assign rt       = if_inst[20:16];
    assign rd       = if_inst[15:11];
    assign funct    = if_inst[5:0];
    assign imm_sext = {{16{if_inst[15]}}, if_inst[15:0]};
    assign imm_zext = {16'h0000, if_inst[15:0]};

    assign gpr_raddr1 = rs;
    assign gpr_raddr2 = rt;

    // A load still in EX has no data yet, so it is never a forwarding source.
    function automatic logic [31:0] forward(
        input logic [4:0]  addr,
        input logic [31:0] rdata,
        input logic        e_we,
        input logic        e_load,
        input logic [4:0]  e_addr,
        input logic [31:0] e_data,
        input logic        m_we,
        input logic [4:0]  m_addr,
        input logic [31:0] m_data
    );
        logic [31:0] val;
        if (addr == 5'd0) begin
            val = 32'h0000_0000;
        end else if (e_we && !e_load && (e_addr == addr)) begin
            val = e_data;
        end else if (m_we && (m_addr == addr)) begin
            val = m_data;
        end else begin
            val = rdata;
        end
        return val;
    endfunction

    assign fwd1 = forward(rs, gpr_rdata1, ex_we, ex_is_load, ex_waddr, ex_wdata,
                          mem_we, mem_waddr, mem_wdata);
    assign fwd2 = forward(rt, gpr_rdata2, ex_we, ex_is_load, ex_waddr, ex_wdata,
                          mem_we, mem_waddr, mem_wdata);

    // Instruction decode into the next ID/EX contents.
    always_comb begin
        dec      = '0;
        dec.pc   = if_pc;
        gpr_re1  = 1'b0;
        gpr_re2  = 1'b0;
        has_dest = 1'b0;
        if (if_inst == 32'h0000_0000) begin
            dec.valid = 1'b1;
        end else begin
            dec.valid = 1'b1;
            gpr_re1   = 1'b1;
            case (opcode)
                OP_RTYPE: begin
                    gpr_re2       = 1'b1;
                    has_dest      = 1'b1;
                    dec.wreg_addr = rd;
                    dec.opnd2     = fwd2;
                    case (funct)
                        FN_ADDU: dec.alu_op = ALU_ADD;
                        FN_SUBU: dec.alu_op = ALU_SUB;
                        FN_AND:  dec.alu_op = ALU_AND;
                        FN_OR:   dec.alu_op = ALU_OR;
                        FN_XOR:  dec.alu_op = ALU_XOR;
                        FN_SLT:  dec.alu_op = ALU_SLT;
                        default: begin
                            dec.valid   = 1'b0;
                            dec.illegal = 1'b1;
                        end
                    endcase
                end
                OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
                    has_dest      = 1'b1;
                    dec.wreg_addr = rt;
                    dec.mem_read  = (opcode == OP_LW);
                    case (opcode)
                        OP_ANDI: begin dec.alu_op = ALU_AND;   dec.opnd2 = imm_zext; end
                        OP_ORI:  begin dec.alu_op = ALU_OR;    dec.opnd2 = imm_zext; end
                        OP_XORI: begin dec.alu_op = ALU_XOR;   dec.opnd2 = imm_zext; end
                        OP_LUI:  begin dec.alu_op = ALU_PASS2; dec.opnd2 = {if_inst[15:0], 16'h0000}; end
                        default: begin dec.alu_op = ALU_ADD;   dec.opnd2 = imm_sext; end
                    endcase
                end
                OP_SW: begin
                    gpr_re2        = 1'b1;
                    dec.alu_op     = ALU_ADD;
                    dec.opnd2      = imm_sext;
                    dec.store_data = fwd2;
                    dec.mem_write  = 1'b1;
                end
                default: begin
                    dec.valid   = 1'b0;
                    dec.illegal = 1'b1;
                end
            endcase
            // Unsupported encodings read nothing so they cannot raise a stall.
            if (dec.illegal) begin
                gpr_re1       = 1'b0;
                gpr_re2       = 1'b0;
                has_dest      = 1'b0;
                dec.alu_op    = ALU_ADD;
                dec.opnd2     = 32'h0000_0000;
                dec.wreg_addr = 5'd0;
            end else begin
                dec.opnd1 = fwd1;
            end
        end
        dec.wreg_en = has_dest && (dec.wreg_addr != 5'd0);
    end

    assign load_hit1 = gpr_re1 && (rs != 5'd0) && ex_we && ex_is_load && (ex_waddr == rs);
    assign load_hit2 = gpr_re2 && (rt != 5'd0) && ex_we && ex_is_load && (ex_waddr == rt);
    assign stall_req = !reset && (load_hit1 || load_hit2);

    // Bubble carries only the PC so exception logic downstream still sees it.
    always_comb begin
        bubble    = '0;
        bubble.pc = if_pc;
    end

    // ID/EX pipeline register: reset, flush, hold, load-use bubble, load.
    always_ff @(posedge clock) begin
        if (reset) begin
            idex <= '0;
        end else if (flush || (!stall && stall_req)) begin
            idex <= bubble;
        end else if (!stall) begin
            idex <= dec;
        end
    end

    assign idex_valid      = idex.valid;
    assign idex_alu_op     = idex.alu_op;
    assign idex_opnd1      = idex.opnd1;
    assign idex_opnd2      = idex.opnd2;
    assign idex_store_data = idex.store_data;
    assign idex_mem_read   = idex.mem_read;
    assign idex_mem_write  = idex.mem_write;
    assign idex_wreg_en    = idex.wreg_en;
    assign idex_wreg_addr  = idex.wreg_addr;
    assign idex_pc         = idex.pc;
    assign idex_illegal    = idex.illegal;

endmodule
